sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Single-clock FIFO controller. Owns the write and read pointers around a 1-write/1-read synchronous RAM.
- Write-side ready/valid is the producer end. Read-side ready/valid is the consumer end, in first-word-fall-through style. The RAM's registered read output doubles as the output stage.
- This is the block that pushes data into the team's RAM storage and drains it back out, giving upstream/downstream stream logic a standard flow-controlled buffer.

Parameters:
- DATA, 16, data word width in bits.
- ADDR, 5, RAM address width; DEPTH = 2**ADDR entries total capacity.

Ports:
- clK  in  1  clock, all logic on posedge.
- rstN  in  1  synchronous active-low reset.
- wr_VALID  in  1  producer has a word.
- wr_READY  out  1  controller can accept; push = wr_VALID & wr_READY.
- wr_DATA  in  DATA  producer word.
- rd_VALID  out  1  rd_DATA holds the head word.
- rd_READY  in  1  consumer takes the word; pop = rd_VALID & rd_READY.
- rd_DATA  out  DATA  head word (registered RAM output).
- level  out  ADDR+1  total occupancy: RAM entries plus the output stage.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.

Behaviour:
- Reset (rstN low at posedge):
  - wptr, rptr, level and ram_cnt go to 0; rd_VALID = 0; full = 0; empty = 1.
  - rd_DATA is don't-care.
  - wr_READY = 0 while rstN is low (gated combinationally), 1 in the first cycle after release.
  - Reset mid-operation discards all contents, including any in-flight fetch; no pop occurs on that edge.
- Pointers:
  - wptr and rptr are ADDR bits and wrap modulo DEPTH.
  - ram_cnt (ADDR+1 bits) = words in RAM not yet fetched.
- Push:
  - wr_READY = rstN & ~full. full is registered from level and does not consider a same-cycle pop, so there is no write pass-through when full.
  - On push: RAM[wptr] <= wr_DATA, wptr++, ram_cnt++.
- Fetch:
  - fetch = (ram_cnt != 0) & (~rd_VALID | rd_READY).
  - On fetch: RAM read enable asserted at rptr, rptr++, ram_cnt--, rd_VALID <= 1 next cycle with rd_DATA = RAM[old rptr].
  - If ~fetch and pop: rd_VALID <= 0.
  - If ~fetch and no pop: rd_DATA and rd_VALID hold (RAM read enable low holds the output register).
- Latency:
  - First-word latency: push in cycle t gives rd_VALID = 1 in cycle t+2.
  - Steady state with rd_READY held high: one pop per cycle, no bubbles.
- Counters:
  - ram_cnt net = +push −fetch, both allowed in the same cycle.
  - level net = +push −pop, both allowed in the same cycle; level never exceeds DEPTH.
  - empty and full are registered from next-level.
- Collisions:
  - Same-address read/write cannot occur: fetch only addresses entries already counted in ram_cnt, i.e. written on an earlier edge.
- Illegal pushes and pops are impossible by construction:
  - wr_VALID while full is ignored; the word is not accepted.
  - rd_READY while empty has no effect.
- Wrap:
  - wptr/rptr roll DEPTH−1 → 0 with no gap.
  - Example: 3·DEPTH sequential words arrive in order.

Optional Feature:
- Macro: FIFO_WATERMARK_EN.
- When defined:
  - Adds parameters AF_LEVEL (default DEPTH−2) and AE_LEVEL (default 2).
  - Adds outputs almost_FULL (level >= AF_LEVEL) and almost_EMPTY (level <= AE_LEVEL), both registered from next-level.
  - Reset values: almost_FULL = 0, almost_EMPTY = 1.
- When undefined: these ports and parameters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - DEPTH = 2**ADDR derivation.
  - PTR_W = ADDR and CNT_W = ADDR+1 width constants.
  - Default watermark constants.
- One sub-module, fifo_mem:
  - 1W1R synchronous RAM with a write port (we, waddr, wdata).
  - Read port (re, raddr, q): q registered, updated only when re is high.
- Pointer, counter and flag logic stays in sync_fifo_ctrl.

Test Plan:
- Reset then idle: wr_READY = 0 during reset; after release wr_READY = 1, rd_VALID = 0, level = 0, empty = 1.
- Single word: push 0xA5A5 at cycle t, rd_READY = 0 → rd_VALID = 1 at t+2, rd_DATA = 0xA5A5, level = 1; pop → empty = 1 next cycle.
- Fill to full (DEPTH = 32) with 0..31, rd_READY = 0:
  - full = 1, wr_READY = 0, level = 32.
  - A 33rd push attempt is not accepted.
  - Drain yields 0..31 in order.
- Streaming: wr_VALID = rd_READY = 1 for 100 cycles with incrementing data → after 2-cycle latency, one pop per cycle in order; level settles at 2 (one word in RAM, one in the output stage).
- Full with simultaneous pop: at level = 32 assert wr_VALID and rd_READY → pop occurs, push refused that cycle, level = 31; push accepted the following cycle.
- Wrap and reset mid-stream:
  - Random valid/ready for 96 words → scoreboard matches.
  - Assert rstN = 0 with level = 10 → next cycle level = 0, rd_VALID = 0, and no stale data appears afterwards.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO controller and its RAM.
// Watermark defaults are only consumed when FIFO_WATERMARK_EN is defined.
package fifo_pkg;

    localparam int DATA_DEF  = 16;
    localparam int ADDR_DEF  = 5;

    // Number of RAM entries for a given address width.
    function automatic int fifo_depth(input int addr);
        return 32'sd1 << addr;
    endfunction

    localparam int DEPTH_DEF = fifo_depth(ADDR_DEF);
    localparam int PTR_W     = ADDR_DEF;
    localparam int CNT_W     = ADDR_DEF + 1;

    // Default watermark thresholds for the default geometry.
    localparam int AF_DEF    = DEPTH_DEF - 2;
    localparam int AE_DEF    = 2;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer ready-valid bundle of the FIFO controller.
// master = the stream logic around the FIFO, slave = the controller.
interface sync_fifo_ctrl_if #(
    parameter int DATA = 16
);
    logic            wr_VALID;
    logic            wr_READY;
    logic [DATA-1:0] wr_DATA;
    logic            rd_VALID;
    logic            rd_READY;
    logic [DATA-1:0] rd_DATA;

    modport master (
        output wr_VALID, wr_DATA, rd_READY,
        input  wr_READY, rd_VALID, rd_DATA
    );

    modport slave (
        input  wr_VALID, wr_DATA, rd_READY,
        output wr_READY, rd_VALID, rd_DATA
    );
endinterface

// File: rtl/fifo_mem.sv
// 1-write/1-read synchronous RAM. The read register only updates when re
// is high, so it holds the head word while the consumer stalls.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA = DATA_DEF,
    parameter int ADDR = ADDR_DEF
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ADDR-1:0] waddr,
    input  logic [DATA-1:0] wdata,
    input  logic            re,
    input  logic [ADDR-1:0] raddr,
    output logic [DATA-1:0] q
);

    localparam int DEPTH = fifo_depth(ADDR);

    logic [DATA-1:0] mem_r [DEPTH];
    logic [DATA-1:0] q_r;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; doubles as the FIFO output stage.
    always_ff @(posedge clk) begin
        if (re) begin
            q_r <= mem_r[raddr];
        end
    end

    assign q = q_r;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock first-word-fall-through FIFO controller around fifo_mem.
// level counts RAM words plus the word held in the RAM output register.
// Optional FIFO_WATERMARK_EN adds almost_FULL / almost_EMPTY flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA = DATA_DEF,
    parameter int ADDR = ADDR_DEF
`ifdef FIFO_WATERMARK_EN
    ,
    parameter int AF_LEVEL = fifo_depth(ADDR) - 2,
    parameter int AE_LEVEL = AE_DEF
`endif
) (
    input  logic                 clK,
    input  logic                 rstN,
    sync_fifo_ctrl_if.slave      bus,
    output logic [ADDR:0]        level,
    output logic                 empty,
    output logic                 full
`ifdef FIFO_WATERMARK_EN
    ,
    output logic                 almost_FULL,
    output logic                 almost_EMPTY
`endif
);

    localparam int DEPTH  = fifo_depth(ADDR);
    localparam int P_W    = ADDR;
    localparam int C_W    = ADDR + 1;
    localparam logic [C_W-1:0] DEPTH_CNT = C_W'(DEPTH);

    logic [P_W-1:0]  wptr_r;
    logic [P_W-1:0]  rptr_r;
    logic [C_W-1:0]  ram_cnt_r;
    logic [C_W-1:0]  level_r;
    logic            rd_valid_r;
    logic            empty_r;
    logic            full_r;

    logic            wr_ready_s;
    logic            push_s;
    logic            pop_s;
    logic            fetch_s;
    logic            rd_valid_nxt_s;
    logic [C_W-1:0]  level_nxt_s;
    logic [C_W-1:0]  ram_cnt_nxt_s;
    logic [DATA-1:0] rd_data_s;

    // Full is registered and ignores a same-cycle pop, so no write pass-through.
    assign wr_ready_s = rstN & ~full_r;

    // Handshakes, fetch decision and next-state counters.
    always_comb begin
        push_s        = bus.wr_VALID & wr_ready_s;
        pop_s         = rd_valid_r & bus.rd_READY;
        fetch_s       = (ram_cnt_r != {C_W{1'b0}}) & (~rd_valid_r | bus.rd_READY) & rstN;
        level_nxt_s   = level_r + C_W'(push_s) - C_W'(pop_s);
        ram_cnt_nxt_s = ram_cnt_r + C_W'(push_s) - C_W'(fetch_s);
        rd_valid_nxt_s = rd_valid_r;
        if (fetch_s) begin
            rd_valid_nxt_s = 1'b1;
        end else if (pop_s) begin
            rd_valid_nxt_s = 1'b0;
        end else begin
            rd_valid_nxt_s = rd_valid_r;
        end
    end

    // Pointers, counters and status flags; reset discards in-flight fetches.
    always_ff @(posedge clK) begin
        if (!rstN) begin
            wptr_r     <= {P_W{1'b0}};
            rptr_r     <= {P_W{1'b0}};
            ram_cnt_r  <= {C_W{1'b0}};
            level_r    <= {C_W{1'b0}};
            rd_valid_r <= 1'b0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
        end else begin
            wptr_r     <= wptr_r + P_W'(push_s);
            rptr_r     <= rptr_r + P_W'(fetch_s);
            ram_cnt_r  <= ram_cnt_nxt_s;
            level_r    <= level_nxt_s;
            rd_valid_r <= rd_valid_nxt_s;
            empty_r    <= (level_nxt_s == {C_W{1'b0}});
            full_r     <= (level_nxt_s == DEPTH_CNT);
        end
    end

`ifdef FIFO_WATERMARK_EN
    localparam logic [C_W-1:0] AF_CNT = C_W'(AF_LEVEL);
    localparam logic [C_W-1:0] AE_CNT = C_W'(AE_LEVEL);

    logic almost_full_r;
    logic almost_empty_r;

    // Watermark flags registered from the next occupancy.
    always_ff @(posedge clK) begin
        if (!rstN) begin
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            almost_full_r  <= (level_nxt_s >= AF_CNT);
            almost_empty_r <= (level_nxt_s <= AE_CNT);
        end
    end

    assign almost_FULL  = almost_full_r;
    assign almost_EMPTY = almost_empty_r;
`endif

    fifo_mem #(
        .DATA (DATA),
        .ADDR (ADDR)
    ) u_mem (
        .clk   (clK),
        .we    (push_s),
        .waddr (wptr_r),
        .wdata (bus.wr_DATA),
        .re    (fetch_s),
        .raddr (rptr_r),
        .q     (rd_data_s)
    );

    assign bus.wr_READY = wr_ready_s;
    assign bus.rd_VALID = rd_valid_r;
    assign bus.rd_DATA  = rd_data_s;
    assign level        = level_r;
    assign empty        = empty_r;
    assign full         = full_r;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: directed stimulus, queue-based scoreboard.
module tb_sync_fifo_ctrl;

    localparam int DATA  = 16;
    localparam int ADDR  = 5;
    localparam int DEPTH = 32;

    logic            clK = 1'b0;
    logic            rstN = 1'b0;
    logic [ADDR:0]   level;
    logic            empty;
    logic            full;
`ifdef FIFO_WATERMARK_EN
    logic            almost_FULL;
    logic            almost_EMPTY;
`endif

    sync_fifo_ctrl_if #(.DATA(DATA)) bus ();

    sync_fifo_ctrl #(
        .DATA (DATA),
        .ADDR (ADDR)
    ) dut (
        .clK          (clK),
        .rstN         (rstN),
        .bus          (bus.slave),
        .level        (level),
        .empty        (empty),
        .full         (full)
`ifdef FIFO_WATERMARK_EN
        ,
        .almost_FULL  (almost_FULL),
        .almost_EMPTY (almost_EMPTY)
`endif
    );

    always #5 clK = ~clK;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [DATA-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clK);
        #1;
    endtask

    // Monitor: on the falling edge check every pop against the queue, then log pushes.
    always @(negedge clK) begin
        if (!rstN) begin
            exp_q.delete();
        end else begin
            if (bus.rd_VALID && bus.rd_READY) begin
                pops++;
                chk("sb_has_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("sb_rd_data", 32'(bus.rd_DATA), 32'(exp_q.pop_front()));
                end
            end
            if (bus.wr_VALID && bus.wr_READY) begin
                exp_q.push_back(bus.wr_DATA);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        bus.rd_READY = 1'b1;
        while (!empty && n < 200) begin
            step();
            n++;
        end
        bus.rd_READY = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        int p0;
        int sent;
        int cyc;
        logic will_push;

        bus.wr_VALID = 1'b0;
        bus.wr_DATA  = 16'h0000;
        bus.rd_READY = 1'b0;
        rstN         = 1'b0;

        // Reset then idle
        repeat (3) step();
        chk("rst_wr_ready", 32'(bus.wr_READY), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_VALID), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
`ifdef FIFO_WATERMARK_EN
        chk("rst_almost_full", 32'(almost_FULL), 32'd0);
        chk("rst_almost_empty", 32'(almost_EMPTY), 32'd1);
`endif
        rstN = 1'b1;
        #1;
        chk("release_wr_ready", 32'(bus.wr_READY), 32'd1);
        step();
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_rd_valid", 32'(bus.rd_VALID), 32'd0);

        // Single word: visible two cycles after the push cycle
        bus.wr_VALID = 1'b1;
        bus.wr_DATA  = 16'hA5A5;
        step();
        bus.wr_VALID = 1'b0;
        chk("single_t1_rd_valid", 32'(bus.rd_VALID), 32'd0);
        chk("single_t1_level", 32'(level), 32'd1);
        step();
        chk("single_t2_rd_valid", 32'(bus.rd_VALID), 32'd1);
        chk("single_t2_rd_data", 32'(bus.rd_DATA), 32'h0000_A5A5);
        chk("single_t2_level", 32'(level), 32'd1);
        step();
        chk("single_hold_rd_data", 32'(bus.rd_DATA), 32'h0000_A5A5);
        bus.rd_READY = 1'b1;
        step();
        bus.rd_READY = 1'b0;
        chk("single_pop_empty", 32'(empty), 32'd1);
        chk("single_pop_rd_valid", 32'(bus.rd_VALID), 32'd0);

        // Fill to full with 0..31
        p0 = pops;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_VALID = 1'b1;
            bus.wr_DATA  = 16'(i);
            step();
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd32);
        chk("fill_wr_ready", 32'(bus.wr_READY), 32'd0);
`ifdef FIFO_WATERMARK_EN
        chk("fill_almost_full", 32'(almost_FULL), 32'd1);
`endif
        bus.wr_DATA = 16'hDEAD;
        step();
        chk("overfill_level", 32'(level), 32'd32);

        // Full with simultaneous pop: pop happens, push refused
        bus.wr_DATA  = 16'h0020;
        bus.rd_READY = 1'b1;
        step();
        bus.rd_READY = 1'b0;
        chk("full_pop_level", 32'(level), 32'd31);
        chk("full_pop_wr_ready", 32'(bus.wr_READY), 32'd1);
        step();
        bus.wr_VALID = 1'b0;
        chk("full_next_push_level", 32'(level), 32'd32);
        drain();
        chk("fill_pop_count", 32'(pops - p0), 32'd33);

        // Streaming: push and pop every cycle
        p0 = pops;
        bus.wr_VALID = 1'b1;
        bus.rd_READY = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.wr_DATA = 16'h1000 + 16'(i);
            step();
        end
        bus.wr_VALID = 1'b0;
        chk("stream_level", 32'(level), 32'd2);
        chk("stream_pops", 32'(pops - p0), 32'd98);
        drain();

        // Random valid/ready across several pointer wraps
        sent = 0;
        cyc  = 0;
        while (sent < 96 && cyc < 3000) begin
            bus.wr_VALID = 1'($urandom_range(0, 1));
            bus.wr_DATA  = 16'h2000 + 16'(sent);
            bus.rd_READY = 1'($urandom_range(0, 1));
            will_push    = bus.wr_VALID & bus.wr_READY;
            step();
            if (will_push) begin
                sent++;
            end
            cyc++;
        end
        bus.wr_VALID = 1'b0;
        chk("random_all_sent", 32'(sent), 32'd96);
        drain();

        // Reset mid-stream with ten words stored
        for (int i = 0; i < 10; i++) begin
            bus.wr_VALID = 1'b1;
            bus.wr_DATA  = 16'h5000 + 16'(i);
            step();
        end
        bus.wr_VALID = 1'b0;
        chk("pre_reset_level", 32'(level), 32'd10);
        rstN         = 1'b0;
        bus.rd_READY = 1'b1;
        step();
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_rd_valid", 32'(bus.rd_VALID), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_stale", 32'(bus.rd_VALID), 32'd0);
        end
        bus.rd_READY = 1'b0;
        bus.wr_VALID = 1'b1;
        bus.wr_DATA  = 16'h3333;
        step();
        bus.wr_VALID = 1'b0;
        step();
        chk("post_rst_data", 32'(bus.rd_DATA), 32'h0000_3333);
        drain();
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
